// File: rtl/mac_params.sv
// ----------------------------------------------------------------------------
// mac_params
//   Shared MAC/PCS definitions: AXI-Stream beat geometry (N_SYMBOLS lanes of
//   W_SYMBOL bits, lane 0 = first byte), the frame generator state type and
//   the helper that builds the byte-enable mask of a frame's last beat.
// ----------------------------------------------------------------------------
package mac_params;

  localparam int N_SYMBOLS = 8;
  localparam int W_SYMBOL  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } gen_state_t;

  // tkeep of the last beat of a frame of 'len' bytes: the lowest
  // (len mod N_SYMBOLS) lanes, or every lane when the frame fills the beat.
  function automatic logic [N_SYMBOLS-1:0] last_keep(input logic [15:0] len);
    logic [N_SYMBOLS-1:0] mask;
    int                   rem;
    rem  = int'(len % 16'(N_SYMBOLS));
    mask = '0;
    for (int i = 0; i < N_SYMBOLS; i++) begin
      if (i < rem) mask[i] = 1'b1;
    end
    if (rem == 0) mask = '1;
    return mask;
  endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// ----------------------------------------------------------------------------
// axis_frame_gen
//   Self-timed AXI-Stream frame source for link bring-up and loopback. Emits a
//   run of frames of clamped length L, byte k of frame n = (n + k) mod 256,
//   separated by a programmable idle gap, honouring tready backpressure.
//
// Ports
//   i_tx_clk, i_tx_reset_n     clock, synchronous active-low reset
//   i_start                    start pulse (sampled in IDLE only)
//   i_stop                     level, ends the run at the next frame boundary
//   i_frame_len / i_num_frames / i_gap_cycles
//                              run configuration, latched on start
//                              (i_num_frames = 0 means continuous)
//   m_axis_t*                  AXI-Stream master, all outputs registered
//   o_busy                     high outside IDLE
//   o_done                     one-cycle pulse when the run ends
//   o_frame_cnt                frames completed since reset (wraps)
// ----------------------------------------------------------------------------
module axis_frame_gen
  import mac_params::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 9600
) (
  input  logic                                i_tx_clk,
  input  logic                                i_tx_reset_n,
  input  logic                                i_start,
  input  logic                                i_stop,
  input  logic [15:0]                         i_frame_len,
  input  logic [15:0]                         i_num_frames,
  input  logic [7:0]                          i_gap_cycles,
  output logic                                m_axis_tvalid,
  output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]  m_axis_tdata,
  output logic [N_SYMBOLS-1:0]                m_axis_tkeep,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [31:0]                         o_frame_cnt
);

  function automatic logic [10:0] beats_of(input logic [15:0] len);
    logic [16:0] t;
    t = {1'b0, len} + 17'(N_SYMBOLS - 1);
    return 11'(t / 17'(N_SYMBOLS));
  endfunction

  gen_state_t state, state_d;

  logic [15:0] len_q, frames_q, run_idx;
  logic [10:0] beats_q, beat_idx;
  logic [7:0]  gap_q, gap_cnt;
  logic [31:0] frame_cnt_q;
  logic        busy_q, done_q;

  logic                               vld_p0, last_p0;
  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] data_p0;
  logic [N_SYMBOLS-1:0]               keep_p0;

  logic [15:0] len_clamped, cur_len, run_idx_p1;
  logic [10:0] cur_beats, nxt_idx;
  logic [7:0]  nxt_seed;
  logic        hs, count_hit;
  logic        start_run, load_beat, clr_valid, frame_end, gap_load, done_d;

  logic                               beat_last;
  logic [N_SYMBOLS-1:0]               beat_keep;
  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] beat_data;
  logic [W_SYMBOL-1:0]                base;

  always_comb begin
    if (i_frame_len < 16'(MIN_LEN))      len_clamped = 16'(MIN_LEN);
    else if (i_frame_len > 16'(MAX_LEN)) len_clamped = 16'(MAX_LEN);
    else                                 len_clamped = i_frame_len;
  end

  assign hs         = vld_p0 & m_axis_tready;
  assign run_idx_p1 = run_idx + 16'd1;
  assign count_hit  = (frames_q != 16'd0) && (run_idx_p1 == frames_q);

  // The beat being loaded on a start uses the incoming configuration,
  // since the latched copy only becomes valid on the same edge.
  assign cur_len   = start_run ? len_clamped : len_q;
  assign cur_beats = start_run ? beats_of(len_clamped) : beats_q;

  always_comb begin
    state_d   = state;
    start_run = 1'b0;
    load_beat = 1'b0;
    clr_valid = 1'b0;
    frame_end = 1'b0;
    gap_load  = 1'b0;
    done_d    = 1'b0;
    nxt_seed  = run_idx[7:0];
    nxt_idx   = beat_idx + 11'd1;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_d   = SEND;
          start_run = 1'b1;
          load_beat = 1'b1;
          nxt_seed  = 8'd0;
          nxt_idx   = 11'd0;
        end
      end
      SEND: begin
        if (hs) begin
          if (last_p0) begin
            frame_end = 1'b1;
            if (i_stop || count_hit) begin
              state_d   = IDLE;
              done_d    = 1'b1;
              clr_valid = 1'b1;
            end else if (gap_q != 8'd0) begin
              state_d   = GAP;
              gap_load  = 1'b1;
              clr_valid = 1'b1;
            end else begin
              load_beat = 1'b1;
              nxt_seed  = run_idx_p1[7:0];
              nxt_idx   = 11'd0;
            end
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      GAP: begin
        if (i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt == 8'd1) begin
          state_d   = SEND;
          load_beat = 1'b1;
          nxt_idx   = 11'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern generator: one adder per lane, disabled lanes forced to zero.
  always_comb begin
    beat_last = (nxt_idx == cur_beats - 11'd1);
    beat_keep = beat_last ? last_keep(cur_len) : '1;
    base      = nxt_seed + W_SYMBOL'(32'(nxt_idx) * N_SYMBOLS);
    for (int i = 0; i < N_SYMBOLS; i++) begin
      beat_data[i] = beat_keep[i] ? base + W_SYMBOL'(i) : '0;
    end
  end

  always_ff @(posedge i_tx_clk) begin
    if (!i_tx_reset_n) begin
      state       <= IDLE;
      len_q       <= '0;
      beats_q     <= '0;
      frames_q    <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      run_idx     <= '0;
      beat_idx    <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_p0      <= 1'b0;
      last_p0     <= 1'b0;
      data_p0     <= '0;
      keep_p0     <= '0;
    end else begin
      state  <= state_d;
      busy_q <= (state_d != IDLE);
      done_q <= done_d;
      if (start_run) begin
        len_q    <= len_clamped;
        beats_q  <= beats_of(len_clamped);
        frames_q <= i_num_frames;
        gap_q    <= i_gap_cycles;
        run_idx  <= '0;
      end else if (frame_end) begin
        run_idx <= run_idx_p1;
      end
      if (frame_end) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (gap_load)          gap_cnt <= gap_q;
      else if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
      // output stage p0
      if (load_beat) begin
        vld_p0   <= 1'b1;
        last_p0  <= beat_last;
        data_p0  <= beat_data;
        keep_p0  <= beat_keep;
        beat_idx <= nxt_idx;
      end else if (clr_valid) begin
        vld_p0  <= 1'b0;
        last_p0 <= 1'b0;
        data_p0 <= '0;
        keep_p0 <= '0;
      end
    end
  end

  assign m_axis_tvalid = vld_p0;
  assign m_axis_tdata  = data_p0;
  assign m_axis_tkeep  = keep_p0;
  assign m_axis_tlast  = last_p0;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, tready;
  logic [15:0] frame_len, num_frames;
  logic [7:0]  gap;
  logic        tvalid, tlast, busy, done;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [31:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_keep[$];
  logic        cap_last[$];
  int          gaps[$];
  int          stall_bad, done_seen;

  always #5 clk = ~clk;

  axis_frame_gen dut (
    .i_tx_clk      (clk),
    .i_tx_reset_n  (rst_n),
    .i_start       (start),
    .i_stop        (stop),
    .i_frame_len   (frame_len),
    .i_num_frames  (num_frames),
    .i_gap_cycles  (gap),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .o_busy        (busy),
    .o_done        (done),
    .o_frame_cnt   (frame_cnt)
  );

  // Reference beat: byte k = (seed + k) mod 256 for k < len, else 0.
  function automatic logic [63:0] exp_beat(input int seed, input int b, input int len);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b * 8 + i < len) r[i*8 +: 8] = 8'((seed + b * 8 + i) % 256);
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_keep(input int b, input int len);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (b * 8 + i < len) r[i] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    frame_len = '0; num_frames = '0; gap = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run(input int len, input int nf, input int g);
    frame_len  = 16'(len);
    num_frames = 16'(nf);
    gap        = 8'(g);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Collects accepted beats until o_done or the cycle budget runs out.
  task automatic capture(input bit rnd, input int stop_at, input int max_cycles);
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl, prev_stall, after_last;
    int          idle;
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); gaps.delete();
    stall_bad = 0; done_seen = 0; idle = 0;
    prev_stall = 1'b0; after_last = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (prev_stall && (tvalid !== 1'b1 || tdata !== pd || tkeep !== pk || tlast !== pl))
        stall_bad++;
      if (done === 1'b1) begin
        done_seen++;
        break;
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid === 1'b1) begin
        if (after_last) begin
          gaps.push_back(idle);
          after_last = 1'b0;
        end
        if (tready) begin
          cap_data.push_back(tdata);
          cap_keep.push_back(tkeep);
          cap_last.push_back(tlast);
          if (tlast === 1'b1) begin
            after_last = 1'b1;
            idle = 0;
          end
          if (stop_at > 0 && cap_data.size() == stop_at) stop = 1'b1;
        end
      end else if (after_last) begin
        idle++;
      end
      prev_stall = tvalid && !tready;
      pd = tdata; pk = tkeep; pl = tlast;
      @(negedge clk);
    end
    stop   = 1'b0;
    tready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    frame_len = '0; num_frames = '0; gap = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tvalid, tlast, tkeep, busy, done} !== 12'h000) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=000", {tvalid, tlast, tkeep, busy, done});
    end
    checks++;
    if (tdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_tdata got=%h exp=0", tdata);
    end
    checks++;
    if (frame_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int bad;
    do_reset();
    start_run(64, 1, 0);
    checks++;
    if (tvalid !== 1'b1) begin
      failures++;
      $display("FAIL start_latency tvalid got=%b exp=1", tvalid);
    end
    capture(1'b0, 0, 200);
    checks++;
    if (cap_data.size() != 8) begin
      failures++;
      $display("FAIL single_beats got=%0d exp=8", cap_data.size());
    end else begin
      checks++;
      if (cap_data[0] !== 64'h0706050403020100) begin
        failures++;
        $display("FAIL single_first got=%h exp=0706050403020100", cap_data[0]);
      end
      bad = 0;
      for (int b = 0; b < 8; b++)
        if (cap_data[b] !== exp_beat(0, b, 64) || cap_keep[b] !== 8'hFF || cap_last[b] !== (b == 7))
          bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL single_beats_content bad=%0d exp=0", bad);
      end
    end
    checks++;
    if (done_seen != 1) begin
      failures++;
      $display("FAIL single_done got=%0d exp=1", done_seen);
    end
    checks++;
    if (frame_cnt !== 32'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_cnt_busy got=%0d/%b exp=1/0", frame_cnt, busy);
    end
  endtask

  task automatic test_odd_length();
    do_reset();
    start_run(61, 1, 0);
    capture(1'b0, 0, 200);
    checks++;
    if (cap_data.size() != 8) begin
      failures++;
      $display("FAIL odd_beats got=%0d exp=8", cap_data.size());
    end else begin
      checks++;
      if (cap_keep[7] !== 8'h1F || cap_data[7] !== 64'h0000003C3B3A3938 || cap_last[7] !== 1'b1) begin
        failures++;
        $display("FAIL odd_last got=%h/%h exp=1F/0000003C3B3A3938", cap_keep[7], cap_data[7]);
      end
    end
    // Short request clamps up to 60 bytes.
    do_reset();
    start_run(10, 1, 0);
    capture(1'b0, 0, 200);
    checks++;
    if (cap_data.size() != 8) begin
      failures++;
      $display("FAIL clamp_min_beats got=%0d exp=8", cap_data.size());
    end else begin
      checks++;
      if (cap_keep[7] !== 8'h0F || cap_data[7] !== 64'h000000003B3A3938) begin
        failures++;
        $display("FAIL clamp_min_last got=%h/%h exp=0F/000000003B3A3938", cap_keep[7], cap_data[7]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    start_run(100, 1, 0);
    capture(1'b1, 0, 1000);
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL bp_stable got=%0d exp=0", stall_bad);
    end
    checks++;
    if (cap_data.size() != 13) begin
      failures++;
      $display("FAIL bp_beats got=%0d exp=13", cap_data.size());
    end else begin
      bad = 0;
      for (int b = 0; b < 13; b++)
        if (cap_data[b] !== exp_beat(0, b, 100) || cap_keep[b] !== exp_keep(b, 100) || cap_last[b] !== (b == 12))
          bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL bp_content bad=%0d exp=0", bad);
      end
      checks++;
      if (cap_keep[12] !== 8'h0F) begin
        failures++;
        $display("FAIL bp_last_keep got=%h exp=0F", cap_keep[12]);
      end
    end
    checks++;
    if (done_seen != 1 || frame_cnt !== 32'd1) begin
      failures++;
      $display("FAIL bp_done got=%0d/%0d exp=1/1", done_seen, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int pass = 0; pass < 2; pass++) begin
      int g;
      g = (pass == 0) ? 0 : 5;
      do_reset();
      start_run(60, 3, g);
      capture(1'b0, 0, 400);
      checks++;
      if (cap_data.size() != 24) begin
        failures++;
        $display("FAIL b2b_beats gap=%0d got=%0d exp=24", g, cap_data.size());
      end else begin
        bad = 0;
        for (int b = 0; b < 24; b++)
          if (cap_data[b] !== exp_beat(b / 8, b % 8, 60) || cap_keep[b] !== exp_keep(b % 8, 60) ||
              cap_last[b] !== ((b % 8) == 7))
            bad++;
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL b2b_content gap=%0d bad=%0d exp=0", g, bad);
        end
      end
      checks++;
      if (gaps.size() != 2 || gaps[0] != g || gaps[1] != g) begin
        failures++;
        $display("FAIL b2b_gaps gap=%0d got_n=%0d first=%0d exp=2x%0d", g, gaps.size(),
                 (gaps.size() > 0) ? gaps[0] : -1, g);
      end
      checks++;
      if (frame_cnt !== 32'd3 || done_seen != 1) begin
        failures++;
        $display("FAIL b2b_cnt gap=%0d got=%0d/%0d exp=3/1", g, frame_cnt, done_seen);
      end
    end
  endtask

  task automatic test_clamp_stop();
    int bad, lasts;
    do_reset();
    start_run(20000, 0, 0);
    capture(1'b0, 300, 4000);
    checks++;
    if (cap_data.size() != 1200) begin
      failures++;
      $display("FAIL stop_beats got=%0d exp=1200", cap_data.size());
    end else begin
      bad = 0; lasts = 0;
      for (int b = 0; b < 1200; b++) begin
        if (cap_data[b] !== exp_beat(0, b, 9600) || cap_keep[b] !== 8'hFF) bad++;
        if (cap_last[b] === 1'b1) lasts++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL stop_content bad=%0d exp=0", bad);
      end
      checks++;
      if (lasts != 1 || cap_last[1199] !== 1'b1 || cap_data[1199] !== 64'h7F7E7D7C7B7A7978) begin
        failures++;
        $display("FAIL stop_last lasts=%0d data=%h exp=1/7F7E7D7C7B7A7978", lasts, cap_data[1199]);
      end
    end
    checks++;
    if (done_seen != 1 || frame_cnt !== 32'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_done got=%0d/%0d/%b exp=1/1/0", done_seen, frame_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    start_run(60, 3, 0);
    tready = 1'b1;
    // first frame (8 beats) plus 4 beats of the seed-1 frame
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tkeep !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b%b%h%b exp=0000", tvalid, tlast, tkeep, busy);
    end
    checks++;
    if (frame_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_cnt got=%0d exp=0", frame_cnt);
    end
    rst_n  = 1'b1;
    tready = 1'b0;
    @(negedge clk);
    start_run(64, 1, 0);
    capture(1'b0, 0, 200);
    checks++;
    if (cap_data.size() != 8 || cap_data[0] !== 64'h0706050403020100) begin
      failures++;
      $display("FAIL rstmid_restart beats=%0d first=%h exp=8/0706050403020100", cap_data.size(),
               (cap_data.size() > 0) ? cap_data[0] : 64'h0);
    end
    checks++;
    if (frame_cnt !== 32'd1) begin
      failures++;
      $display("FAIL rstmid_cnt_after got=%0d exp=1", frame_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    frame_len = '0; num_frames = '0; gap = '0;
    test_reset();
    test_single_frame();
    test_odd_length();
    test_backpressure();
    test_back_to_back();
    test_clamp_stop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Self-timed AXI-Stream frame generator that drives the TX slave AXI-Stream port of the MAC/PCS top. It produces a programmable number of frames with a given length, deterministic byte pattern and inter-frame gap, and honours `tready` backpressure. It is used for link bring-up, loopback and throughput measurement without a host-side data source.

## Interface

Parameters

- `MIN_LEN`, default 60: smallest frame length in bytes; shorter requests are clamped up to this value.
- `MAX_LEN`, default 9600: largest frame length in bytes; longer requests are clamped down to this value.
- `N_SYMBOLS` / `W_SYMBOL`: taken from `mac_params` (8 / 8, giving a 64-bit beat).

Ports (one clock; reset is synchronous and active-low)

- `i_tx_clk`  in  1  TX clock.
- `i_tx_reset_n`  in  1  synchronous, active-low reset.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_stop`  in  1  level; ends the run at the next frame boundary.
- `i_frame_len`  in  16  frame length in bytes; latched on start.
- `i_num_frames`  in  16  number of frames in the run; 0 means continuous. Latched on start.
- `i_gap_cycles`  in  8  idle cycles between frames; latched on start.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tdata`  out  `[N_SYMBOLS-1:0][W_SYMBOL-1:0]`  beat data; lane 0 carries the first byte.
- `m_axis_tkeep`  out  `N_SYMBOLS`  byte enables.
- `m_axis_tlast`  out  1  last beat of the frame.
- `m_axis_tready`  in  1  downstream ready.
- `o_busy`  out  1  high in any state except IDLE.
- `o_done`  out  1  one-cycle pulse when the run ends.
- `o_frame_cnt`  out  32  frames completed since reset; wraps on overflow.

## Operation

- **FSM states:** IDLE, SEND, GAP. The state type is `gen_state_t`.
- **IDLE → SEND** on `i_start`.
  - Latch the clamped length `L`, the frame count, and the gap.
  - Reset the run frame index to 0.
- **SEND:**
  - Emit `B = ceil(L/N_SYMBOLS)` beats.
  - Byte `k` of the frame (`k = 0..L-1`) is `(seed + k) mod 256`, where `seed` is the run frame index mod 256.
  - `tkeep` is all ones on every beat except the last. On the last beat only the lowest `L mod N_SYMBOLS` bits are set, or all ones if the remainder is 0.
  - Disabled lanes carry 0x00.
  - `tlast` is asserted only on beat `B-1`.
- **End of frame:** when the last beat is accepted:
  - `o_frame_cnt++` and the run index increments.
  - If `i_stop` is high, or the count is reached (count ≠ 0), go to IDLE and pulse `o_done`.
  - Otherwise, if gap > 0, go to GAP.
  - Otherwise stay in SEND; the next frame's first beat is presented on the following cycle.
- **GAP:** down-counter loaded with the gap value. `tvalid` is 0. When the counter reaches 1, go to SEND, so exactly `gap` idle cycles are inserted. `i_stop` sampled in GAP moves to IDLE and pulses `o_done`.
- **`i_stop` mid-frame:** has no effect until the frame completes. Frames are never truncated by stop.
- **`i_start` while busy:** ignored. Length, count and gap inputs changing mid-run are ignored.
- **Arithmetic:**
  - Beat counter is 11 bits: `ceil(9600/8) = 1200`.
  - Byte pattern addition is mod 256.
  - Run frame index is 16 bits.

## Timing

- **Reset values:**
  - `tvalid = 0`, `tlast = 0`, `tdata = 0`, `tkeep = 0`.
  - `o_busy = 0`, `o_done = 0`, `o_frame_cnt = 0`.
  - State is IDLE.
- **All outputs are registered.** With `i_start` high in IDLE at cycle t, `tvalid` is 1 at t+1.
- **AXI-Stream rules:**
  - Once `tvalid` is high, `tvalid`, `tdata`, `tkeep` and `tlast` hold until `tvalid & tready`. The beat advances on the cycle after the handshake.
  - `tvalid` never depends combinationally on `tready`.
- **Throughput:** one beat per cycle with `tready` = 1. Back-to-back frames have zero bubbles when gap = 0.
- **Reset mid-frame:** outputs return to their reset values on the next cycle; the partial frame is abandoned with no `tlast`. A following start begins at seed 0.
- **`o_done`:** asserted on the cycle the state becomes IDLE.
- **`o_frame_cnt`:** increments on the cycle after the last-beat handshake.

## Structure

- **`mac_params`:** add `gen_state_t` (IDLE/SEND/GAP) and a function `last_keep(len)` returning the last-beat `tkeep` mask. Reuse `N_SYMBOLS` and `W_SYMBOL`.
- **Sub-modules:** none. The pattern generator is an adder per lane inside the block.

## Test plan

- **Single 64-byte frame:** `len` = 64, frames = 1, `tready` = 1.
  - 8 beats, `tkeep` = 0xFF on all, `tlast` on beat 8.
  - Bytes 0x00..0x3F; `o_done` pulses; `o_frame_cnt` = 1.
- **Odd length:** `len` = 61.
  - Clamped to 61 (MIN 60).
  - 8 beats, last `tkeep` = 0x1F, last-beat bytes 0x38..0x3C with lanes 5–7 = 0.
- **Random backpressure:** `tready` random at 50%, `len` = 100.
  - Outputs stable while stalled; exactly 13 accepted beats; data identical to the `tready` = 1 run.
- **Back-to-back run:** frames = 3, gap = 0.
  - No idle cycle between frames; frame seeds 0, 1, 2; `o_frame_cnt` = 3.
  - Repeat with gap = 5: exactly 5 `tvalid` = 0 cycles between frames.
- **Clamping and stop:** continuous mode with `len` = 20000, clamped to 9600 (1200 beats).
  - Assert `i_stop` at beat 300: the frame completes through beat 1200, then IDLE and `o_done`.
- **Reset mid-frame:** reset at beat 4.
  - `tvalid` = 0 the next cycle and `o_frame_cnt` = 0.
  - A new start emits seed-0 data.
